arithm_sched: RTL and testbench

- Round-robin scheduler that shares one `arithm` fixed-point datapath (14-bit signed operands A/B/C, 29-bit signed result O, advances only while ce=1) among N_REQ requesters.
- Accepts operand triples over valid/ready handshakes and issues at most one triple per cycle into the datapath.
- Tracks in-flight operations through the fixed pipeline latency and returns each result tagged with its requester id.
- Applies downstream backpressure by deasserting the datapath ce, freezing the whole pipeline.

---
 rtl/arithm_pkg.sv | 8 +
 rtl/arithm_sched_rr_arbiter.sv | 42 ++++
 rtl/arithm_sched.sv | 119 +++++++++++
 tb/tb_arithm_sched.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arithm_pkg.sv
// Shared widths and types for the arithm fixed-point datapath and its scheduler.
package arithm_pkg;
  localparam int OPW  = 14;
  localparam int RESW = 29;

  typedef logic signed [OPW-1:0]  operand_t;
  typedef logic signed [RESW-1:0] result_t;
endpackage

// File: rtl/arithm_sched_rr_arbiter.sv
// Round-robin arbiter: first active request at or above ptr_i, else wraps to the lowest.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDW   = 3
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDW-1:0]   idx_o,
  output logic             any_o
);
  logic             hi_found, lo_found;
  logic [IDW-1:0]   hi_idx, lo_idx;

  // Two priority passes: upper half (>= ptr) wins, lower half covers the wrap.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (req_i[j] && !hi_found && (IDW'(j) >= ptr_i)) begin
        hi_found = 1'b1;
        hi_idx   = IDW'(j);
      end
      if (req_i[j] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(j);
      end
    end
  end

  assign any_o = en_i & (hi_found | lo_found);
  assign idx_o = any_o ? (hi_found ? hi_idx : lo_idx) : '0;

  always_comb begin
    gnt_o = '0;
    for (int j = 0; j < N_REQ; j++)
      gnt_o[j] = any_o && (idx_o == IDW'(j));
  end
endmodule

// File: rtl/arithm_sched.sv
// Round-robin scheduler sharing one arithm datapath among N_REQ requesters.
// Optional ARITHM_SCHED_STATS_EN adds saturating issue/stall counters.
module arithm_sched import arithm_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int LAT   = 4,
  parameter int IDW   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [OPW*N_REQ-1:0] req_a,
  input  logic [OPW*N_REQ-1:0] req_b,
  input  logic [OPW*N_REQ-1:0] req_c,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDW-1:0]       res_id,
  output logic [RESW-1:0]      res_o,
  output logic                 dp_ce,
  output logic [OPW-1:0]       dp_a,
  output logic [OPW-1:0]       dp_b,
  output logic [OPW-1:0]       dp_c,
  input  logic [RESW-1:0]      dp_o
`ifdef ARITHM_SCHED_STATS_EN
  ,
  output logic [15:0]          stat_issued,
  output logic [15:0]          stat_stall
`endif
);
  logic [LAT-1:0]           vld_q, vld_d;
  logic [LAT-1:0][IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]         gnt;
  logic [IDW-1:0]           gnt_idx;
  logic                     gnt_any, stall;
  operand_t                 mux_a, mux_b, mux_c;

  // Only a real result at the head can stall; bubbles drain freely.
  assign stall = vld_q[LAT-1] & ~res_ready;
  assign dp_ce = rst_n & ~stall;

  rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (dp_ce),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign req_ready = gnt;

  always_comb begin
    mux_a = '0;
    mux_b = '0;
    mux_c = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (gnt[j]) begin
        mux_a = req_a[OPW*j +: OPW];
        mux_b = req_b[OPW*j +: OPW];
        mux_c = req_c[OPW*j +: OPW];
      end
    end
  end

  assign dp_a = mux_a;
  assign dp_b = mux_b;
  assign dp_c = mux_c;

  assign rr_ptr_d = !gnt_any ? rr_ptr_q :
                    (gnt_idx == IDW'(N_REQ-1)) ? '0 : gnt_idx + IDW'(1);

  // Tracking mirrors the datapath: shifts only on ce-enabled edges.
  always_comb begin
    vld_d = vld_q;
    id_d  = id_q;
    if (dp_ce) begin
      vld_d[0] = gnt_any;
      id_d[0]  = gnt_idx;
      for (int i = 1; i < LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        id_d[i]  = id_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      vld_q    <= vld_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign res_valid = vld_q[LAT-1];
  assign res_id    = id_q[LAT-1];
  assign res_o     = dp_o;

`ifdef ARITHM_SCHED_STATS_EN
  logic [15:0] issued_q, stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (gnt_any && issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
      if (stall && stall_q != 16'hFFFF)    stall_q  <= stall_q + 16'd1;
    end
  end

  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
`endif
endmodule

// File: tb/tb_arithm_sched.sv
// Bench for arithm_sched with a ce-gated 4-stage A*C stub datapath and a queue-based reference model.
module tb_arithm_sched;
  localparam int N = 3, LAT = 4, IDW = 3;

  logic            clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0]    req_valid = '0, req_ready;
  logic [14*N-1:0] req_a = '0, req_b = '0, req_c = '0;
  logic            res_valid, res_ready = 1'b1, dp_ce;
  logic [IDW-1:0]  res_id;
  logic [28:0]     res_o, dp_o;
  logic [13:0]     dp_a, dp_b, dp_c;
`ifdef ARITHM_SCHED_STATS_EN
  logic [15:0]     stat_issued, stat_stall;
`endif

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  arithm_sched #(.N_REQ(N), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_o(res_o),
    .dp_ce(dp_ce), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_o(dp_o)
`ifdef ARITHM_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  function automatic logic [28:0] mul29(input logic [13:0] a, input logic [13:0] c);
    longint p;
    p = longint'($signed(a)) * longint'($signed(c));
    return p[28:0];
  endfunction

  // Stub datapath: O = A*C, LAT stages, frozen when ce=0
  logic [28:0] st [LAT] = '{default: '0};
  always @(posedge clk) begin
    if (dp_ce) begin
      st[0] <= mul29(dp_a, dp_c);
      for (int i = 1; i < LAT; i++) st[i] <= st[i-1];
    end
  end
  assign dp_o = st[LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: in-order queue of issued ops, each aging one step per ce-enabled edge
  typedef struct { int id; logic [28:0] o; int cnt; } ent_t;
  ent_t mq[$];
  int   ptr_m = 0, g_last = -1, iss_m = 0, stl_m = 0;

  function automatic bit head_vis();
    return (mq.size() > 0) && (mq[0].cnt == LAT);
  endfunction

  function automatic bit ce_m();
    return !(head_vis() && !res_ready);
  endfunction

  function automatic int pick();
    if (!ce_m()) return -1;
    for (int k = 0; k < N; k++) if (req_valid[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete(); ptr_m = 0; g_last = -1; iss_m = 0; stl_m = 0;
    end else begin
      bit hv, ce;
      int g;
      hv = head_vis(); ce = ce_m(); g = pick();
      g_last = g;
      if (!ce) stl_m++;
      if (hv && res_ready) void'(mq.pop_front());
      if (ce) begin
        foreach (mq[k]) mq[k].cnt++;
        if (g >= 0) begin
          mq.push_back('{g, mul29(req_a[14*g +: 14], req_c[14*g +: 14]), 1});
          ptr_m = (g + 1) % N;
          iss_m++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_dp_ce", dp_ce, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_req_ready", req_ready, 0);
    end else begin
      int g;
      logic [N-1:0] oh;
      logic [13:0] ea, eb, ec;
      g = pick(); oh = '0; ea = '0; eb = '0; ec = '0;
      if (g >= 0) begin
        oh[g] = 1'b1;
        ea = req_a[14*g +: 14]; eb = req_b[14*g +: 14]; ec = req_c[14*g +: 14];
      end
      chk("dp_ce", dp_ce, ce_m());
      chk("req_ready", req_ready, oh);
      chk("res_valid", res_valid, head_vis());
      if (head_vis()) begin
        chk("res_id", res_id, mq[0].id);
        chk("res_o", res_o, mq[0].o);
      end
      chk("dp_a", dp_a, ea);
      chk("dp_b", dp_b, eb);
      chk("dp_c", dp_c, ec);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic set_op(input int i, input logic [13:0] a, input logic [13:0] b, input logic [13:0] c);
    req_a[14*i +: 14] = a; req_b[14*i +: 14] = b; req_c[14*i +: 14] = c;
  endtask

  typedef struct { logic [13:0] a, b, c; logic [28:0] o; } vec_t;

  initial begin
    vec_t        tv[6];
    int          lat, hs, stalls, ids[$];
    logic [28:0] hold_o;
    logic [IDW-1:0] hold_id;

    tv[0] = '{14'h052D, 14'h3367, 14'h090C, 29'h002ED31C};
    tv[1] = '{14'h1FFF, 14'h0000, 14'h1FFF, 29'h03FFC001};
    tv[2] = '{14'h2000, 14'h1555, 14'h2000, 29'h04000000};
    tv[3] = '{14'h1FFF, 14'h2AAA, 14'h2000, 29'h1C002000};
    tv[4] = '{14'h0000, 14'h3FFF, 14'h1234, 29'h00000000};
    tv[5] = '{14'h3FFF, 14'h0001, 14'h0003, 29'h1FFFFFFD};

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("reset_dp_ce", dp_ce, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_dp_a", dp_a, 0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Idle after reset
    repeat (5) begin
      @(negedge clk);
      chk("idle_dp_ce", dp_ce, 1);
      chk("idle_dp_a", dp_a, 0);
      chk("idle_res_valid", res_valid, 0);
      tick();
    end

    // Single-op vectors: latency, value, id, single-cycle pulse
    foreach (tv[v]) begin
      set_op(0, tv[v].a, tv[v].b, tv[v].c);
      req_valid = 3'b001;
      @(negedge clk);
      chk("tv_ready", req_ready[0], 1);
      tick();
      req_valid = '0;
      lat = 0;
      for (int n = 1; n <= 12 && lat == 0; n++) begin
        @(negedge clk);
        if (res_valid) lat = n; else tick();
      end
      chk("tv_latency", lat, LAT);
      chk("tv_res_o", res_o, tv[v].o);
      chk("tv_res_id", res_id, 0);
      tick();
      @(negedge clk);
      chk("tv_pulse", res_valid, 0);
      tick();
    end

    // Two requesters continuously valid: grants and results alternate
    req_valid = 3'b011;
    set_op(0, 14'($urandom), 14'($urandom), 14'($urandom));
    set_op(1, 14'($urandom), 14'($urandom), 14'($urandom));
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (res_valid) ids.push_back(int'(res_id));
      tick();
      if (c == 7) req_valid = '0;
      else if (g_last >= 0) set_op(g_last, 14'($urandom), 14'($urandom), 14'($urandom));
    end
    chk("alt_count", ids.size(), 8);
    for (int k = 1; k < ids.size(); k++) begin
      chk("alt_id_range", ids[k] <= 1, 1);
      chk("alt_id_toggle", ids[k] != ids[k-1], 1);
    end

    // Reset with ops in flight; pointer must restart at 0
    req_valid = 3'b010;
    repeat (3) begin
      set_op(1, 14'($urandom), 14'($urandom), 14'($urandom));
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_dp_ce", dp_ce, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_dp_a", dp_a, 0);
    tick(); tick();
    req_valid = 3'b110;
    set_op(2, 14'($urandom), 14'($urandom), 14'($urandom));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ptr_restart", req_ready, 3'b010);
    tick();
    req_valid = 3'b100;
    tick();
    req_valid = '0;
    hs = 0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid) hs++;
      tick();
    end
    chk("post_reset_results", hs, 2);

    // 10 issues then 5 stall cycles, from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    hs = 0; stalls = 0; hold_o = '0; hold_id = '0;
    for (int c = 0; c < 40; c++) begin
      req_valid = (c < 10) ? 3'b001 : 3'b000;
      if (c < 10) set_op(0, 14'($urandom), 14'($urandom), 14'($urandom));
      res_ready = !(c >= 10 && c < 15);
      @(negedge clk);
      if (!dp_ce) stalls++;
      if (c == 10) begin hold_o = res_o; hold_id = res_id; end
      if (c > 10 && c < 15) begin
        chk("stall_hold_o", res_o, hold_o);
        chk("stall_hold_id", res_id, hold_id);
      end
      if (res_valid && res_ready) hs++;
      tick();
    end
    chk("stall_cycles", stalls, 5);
    chk("no_loss_dup", hs, 10);
`ifdef ARITHM_SCHED_STATS_EN
    chk("stat_issued_10", stat_issued, 10);
    chk("stat_stall_5", stat_stall, 5);
`endif

    // Randomized traffic with backpressure
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_op(i, 14'($urandom), 14'($urandom), 14'($urandom));
          req_valid[i] = 1'b1;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (g_last >= 0) req_valid[g_last] = 1'b0;
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (LAT + 4) tick();
    @(negedge clk);
    chk("final_res_valid", res_valid, 0);
`ifdef ARITHM_SCHED_STATS_EN
    chk("stat_issued_rand", stat_issued, iss_m);
    chk("stat_stall_rand", stat_stall, stl_m);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
